// File: rtl/fp_div_pkg.sv
// Shared definitions for the sequential IEEE-754 divider.
//   state_e        : controller states (IDLE, DIV, ROUND, DONE)
//   FLG_*          : bit positions inside the 5-bit flags word
//   exp_bias()     : exponent bias for a given exponent width
//   qnan_word()    : canonical quiet NaN (sign 0, exponent all ones,
//                    mantissa MSB set), right-aligned in 64 bits
package fp_div_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DIV   = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int FLG_INV = 4;
  localparam int FLG_DZ  = 3;
  localparam int FLG_OF  = 2;
  localparam int FLG_UF  = 1;
  localparam int FLG_NX  = 0;

  function automatic int exp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Caller slices the low 1+exp_w+man_w bits.
  function automatic logic [63:0] qnan_word(input int exp_w, input int man_w);
    logic [63:0] w;
    w = ((64'd1 << exp_w) - 64'd1) << man_w;
    w = w | (64'd1 << (man_w - 1));
    return w;
  endfunction

endpackage

// File: rtl/fp_div_round.sv
// Combinational back end of the divider: normalise, round-to-nearest-even,
// range check and pack.
//   quo_i    : MAN_W+3 quotient bits, MSB has weight 2^0
//   sticky_i : nonzero final remainder
//   exp_i    : signed biased exponent before normalisation (EXP_W+2 bits)
//   sign_i   : result sign
//   result_o : packed IEEE word
//   of_o, uf_o, nx_o : overflow / underflow / inexact
module fp_div_round
  import fp_div_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [MAN_W+2:0]     quo_i,
  input  logic                 sticky_i,
  input  logic signed [EXP_W+1:0] exp_i,
  input  logic                 sign_i,
  output logic [EXP_W+MAN_W:0] result_o,
  output logic                 of_o,
  output logic                 uf_o,
  output logic                 nx_o
);

  localparam int Q  = MAN_W + 3;
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] ONE_E  = EW'(1);
  localparam logic signed [EW-1:0] ZERO_E = '0;
  localparam logic signed [EW-1:0] EMAX   = EW'((1 << EXP_W) - 1);

  logic [MAN_W-1:0]       mant;
  logic                   guard_b;
  logic                   round_b;
  logic                   round_up;
  logic [MAN_W:0]         sum;
  logic signed [EW-1:0]   e_norm;
  logic signed [EW-1:0]   e_rnd;

  always_comb begin
    // Quotient lies in (0.5, 2): a zero MSB means one extra left shift.
    if (quo_i[Q-1]) begin
      mant    = quo_i[Q-2:2];
      guard_b = quo_i[1];
      round_b = quo_i[0];
      e_norm  = exp_i;
    end else begin
      mant    = quo_i[Q-3:1];
      guard_b = quo_i[0];
      round_b = 1'b0;
      e_norm  = exp_i - ONE_E;
    end

    round_up = guard_b & (round_b | sticky_i | mant[0]);
    sum      = {1'b0, mant} + {{MAN_W{1'b0}}, round_up};
    // Carry out of the fraction: fraction wraps to zero, exponent bumps.
    e_rnd    = e_norm + (sum[MAN_W] ? ONE_E : ZERO_E);

    nx_o     = guard_b | round_b | sticky_i;
    of_o     = 1'b0;
    uf_o     = 1'b0;
    result_o = {sign_i, e_rnd[EXP_W-1:0], sum[MAN_W-1:0]};

    if (e_rnd >= EMAX) begin
      result_o = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      of_o     = 1'b1;
      nx_o     = 1'b1;
    end else if (e_rnd <= ZERO_E) begin
      result_o = {sign_i, {(EXP_W + MAN_W){1'b0}}};
      uf_o     = 1'b1;
      nx_o     = 1'b1;
    end
  end

endmodule

// File: rtl/fp_div_seq.sv
// Sequential radix-2 restoring IEEE-754 divider (one quotient bit per clock).
//   clk, rst         : clock, asynchronous active-high reset
//   in_valid/in_ready: operand handshake, a = dividend, b = divisor
//   out_valid/out_ready: result handshake, result + flags
//   flags            : {invalid, div_by_zero, overflow, underflow, inexact}
//   dbg_state_o      : current controller state
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// in_ready is high only in IDLE; out_valid is high only in DONE, where
// result/flags are held until out_ready. DONE always returns to IDLE
// before another accept, so at most one operation is in flight.
module fp_div_seq
  import fp_div_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [4:0]           flags,
  output state_e               dbg_state_o
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int M  = MAN_W + 1;
  localparam int Q  = MAN_W + 3;
  localparam int CW = $clog2(Q + 1);
  localparam int EW = EXP_W + 2;
  localparam logic [63:0]          QNAN_WIDE = qnan_word(EXP_W, MAN_W);
  localparam logic [W-1:0]         QNAN      = QNAN_WIDE[W-1:0];
  localparam logic signed [EW-1:0] BIAS_E    = EW'(exp_bias(EXP_W));

  // Operand decode
  logic             sa, sb, sign_in;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;

  assign {sa, ea, ma} = a;
  assign {sb, eb, mb} = b;
  assign sign_in = sa ^ sb;
  // Exponent 0 flushes subnormals to zero.
  assign a_zero  = ~|ea;
  assign b_zero  = ~|eb;
  assign a_inf   = (&ea) & ~|ma;
  assign b_inf   = (&eb) & ~|mb;
  assign a_nan   = (&ea) & |ma;
  assign b_nan   = (&eb) & |mb;
  assign a_snan  = a_nan & ~ma[MAN_W-1];
  assign b_snan  = b_nan & ~mb[MAN_W-1];

  logic         spec_hit;
  logic [W-1:0] spec_res;
  logic [4:0]   spec_flg;

  always_comb begin
    spec_hit = 1'b1;
    spec_res = '0;
    spec_flg = '0;
    if (a_nan | b_nan) begin
      spec_res           = QNAN;
      spec_flg[FLG_INV]  = a_snan | b_snan;
    end else if ((a_zero & b_zero) | (a_inf & b_inf)) begin
      spec_res           = QNAN;
      spec_flg[FLG_INV]  = 1'b1;
    end else if (a_inf) begin
      spec_res = {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      spec_res = {sign_in, {(W-1){1'b0}}};
    end else if (b_zero) begin
      spec_res          = {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      spec_flg[FLG_DZ]  = 1'b1;
    end else if (a_zero) begin
      spec_res = {sign_in, {(W-1){1'b0}}};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // Datapath / control registers
  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [M:0]           rem_q, rem_d;   // one spare bit for the shifted remainder
  logic [M-1:0]         div_q, div_d;
  logic [Q-1:0]         quo_q, quo_d;
  logic signed [EW-1:0] exp_q, exp_d;
  logic                 sign_q, sign_d;
  logic [W-1:0]         result_q, result_d;
  logic [4:0]           flags_q, flags_d;

  logic [W-1:0]         rnd_result;
  logic                 rnd_of, rnd_uf, rnd_nx;
  logic                 rem_ge;

  assign rem_ge = rem_q >= {1'b0, div_q};

  fp_div_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
    .quo_i    (quo_q),
    .sticky_i (|rem_q),
    .exp_i    (exp_q),
    .sign_i   (sign_q),
    .result_o (rnd_result),
    .of_o     (rnd_of),
    .uf_o     (rnd_uf),
    .nx_o     (rnd_nx)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    div_d    = div_q;
    quo_d    = quo_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    result_d = result_q;
    flags_d  = flags_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d = sign_in;
          if (spec_hit) begin
            result_d = spec_res;
            flags_d  = spec_flg;
            state_d  = S_DONE;
          end else begin
            rem_d   = {1'b0, 1'b1, ma};
            div_d   = {1'b1, mb};
            quo_d   = '0;
            cnt_d   = '0;
            exp_d   = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_E;
            state_d = S_DIV;
          end
        end
      end
      S_DIV: begin
        // Restoring step: subtract if it fits, record the bit, shift.
        rem_d = (rem_ge ? (rem_q - {1'b0, div_q}) : rem_q) << 1;
        quo_d = {quo_q[Q-2:0], rem_ge};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(Q - 1)) state_d = S_ROUND;
      end
      S_ROUND: begin
        result_d         = rnd_result;
        flags_d          = '0;
        flags_d[FLG_OF]  = rnd_of;
        flags_d[FLG_UF]  = rnd_uf;
        flags_d[FLG_NX]  = rnd_nx;
        state_d          = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      quo_q    <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      quo_q    <= quo_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign result      = result_q;
  assign flags       = flags_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fp_div_seq.sv
module tb_fp_div_seq;
  import fp_div_pkg::*;

  localparam int NORM_LAT = 27;  // edges after the accept edge
  localparam int SPEC_LAT = 0;   // visible right after the accept edge

  logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [4:0]  flags;
  state_e      dbg_state;

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];

  fp_div_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .dbg_state_o(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: exact integer quotient, then RNE on the bits below
  // the 24-bit significand.
  function automatic void ref_div(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [4:0] f,
                                  output bit special);
    logic s;
    logic [7:0] ex, ey;
    logic [22:0] fx, fy;
    bit xn, yn, xi, yi, xz, yz;
    longint num, den, quo, rm, keep, low;
    int e;
    s = x[31] ^ y[31];
    ex = x[30:23]; ey = y[30:23]; fx = x[22:0]; fy = y[22:0];
    xn = (ex == 8'hFF) && (fx != 0); yn = (ey == 8'hFF) && (fy != 0);
    xi = (ex == 8'hFF) && (fx == 0); yi = (ey == 8'hFF) && (fy == 0);
    xz = (ex == 0); yz = (ey == 0);
    r = 32'h0; f = 5'b0; special = 1'b1;
    if (xn || yn) begin
      r = 32'h7FC00000;
      f[4] = (xn && !fx[22]) || (yn && !fy[22]);
    end else if ((xz && yz) || (xi && yi)) begin
      r = 32'h7FC00000; f = 5'b10000;
    end else if (xi) r = {s, 8'hFF, 23'h0};
    else if (yi) r = {s, 31'h0};
    else if (yz) begin r = {s, 8'hFF, 23'h0}; f = 5'b01000; end
    else if (xz) r = {s, 31'h0};
    else begin
      special = 1'b0;
      num = longint'({1'b1, fx});
      den = longint'({1'b1, fy});
      e = int'(ex) - int'(ey) + 127;
      if (num < den) begin num = num << 27; e = e - 1; end
      else num = num << 26;
      quo = num / den; rm = num % den;
      keep = quo >> 3; low = quo & 7;
      f[0] = (low != 0) || (rm != 0);
      if (low > 4 || (low == 4 && (rm != 0 || keep[0]))) keep = keep + 1;
      if (keep == (longint'(1) << 24)) begin keep = keep >> 1; e = e + 1; end
      if (e >= 255) begin r = {s, 8'hFF, 23'h0}; f = 5'b00101; end
      else if (e <= 0) begin r = {s, 31'h0}; f = 5'b00011; end
      else r = {s, e[7:0], keep[22:0]};
    end
  endfunction

  function automatic logic [31:0] gen_operand();
    int k;
    logic [31:0] v;
    k = int'($urandom_range(0, 15));
    v[31] = 1'($urandom_range(0, 1));
    v[22:0] = 23'($urandom);
    if (k == 0) v[30:0] = 31'h0;
    else if (k == 1) v[30:0] = {8'hFF, 23'h0};
    else if (k == 2) v[30:23] = 8'hFF;
    else if (k == 3) v[30:23] = 8'h00;
    else if (k < 12) v[30:23] = 8'($urandom_range(100, 154));
    else v[30:23] = 8'($urandom_range(1, 254));
    if (k == 2 && v[22:0] == 23'h0) v[0] = 1'b1;
    return v;
  endfunction

  // Driver: issue one operation, wait for the result, then consume it.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                        output logic [31:0] r, output logic [4:0] f, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
    a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL timeout a=%h b=%h: out_valid=%b after %0d edges, required 1", av, bv, out_valid, lat);
    end
    r = result; f = flags;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
    checks++; if (flags !== 5'h0) begin errors++; $display("FAIL reset_flags got=%b exp=0", flags); end
    checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, S_IDLE); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] ta [12];
    logic [31:0] tb [12];
    logic [31:0] tr [12];
    logic [4:0]  tf [12];
    int          tl [12];
    logic [31:0] r;
    logic [4:0]  f;
    int lat;
    ta = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'h00000000, 32'h7F000000, 32'h80800000,
           32'h7FA00000, 32'h7FC00000, 32'h7F800000, 32'hFF800000, 32'h3F800000, 32'h00400000};
    tb = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h00000000, 32'h3E800000, 32'h40000000,
           32'h3F800000, 32'h3F800000, 32'h7F800000, 32'h40000000, 32'hFF800000, 32'h3F800000};
    tr = '{32'h40400000, 32'h3EAAAAAB, 32'h7F800000, 32'h7FC00000, 32'h7F800000, 32'h80000000,
           32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h00000000};
    tf = '{5'b00000, 5'b00001, 5'b01000, 5'b10000, 5'b00101, 5'b00011,
           5'b10000, 5'b00000, 5'b10000, 5'b00000, 5'b00000, 5'b00000};
    tl = '{NORM_LAT, NORM_LAT, SPEC_LAT, SPEC_LAT, NORM_LAT, NORM_LAT,
           SPEC_LAT, SPEC_LAT, SPEC_LAT, SPEC_LAT, SPEC_LAT, SPEC_LAT};
    for (int i = 0; i < 12; i++) begin
      run_op(ta[i], tb[i], r, f, lat);
      checks++; if (r !== tr[i]) begin errors++; $display("FAIL dir%0d_result got=%h exp=%h", i, r, tr[i]); end
      checks++; if (f !== tf[i]) begin errors++; $display("FAIL dir%0d_flags got=%b exp=%b", i, f, tf[i]); end
      checks++; if (lat != tl[i]) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, tl[i]); end
    end
  endtask

  task automatic test_random(input int n);
    logic [31:0] x, y, r, er;
    logic [4:0] f, ef;
    bit sp;
    int lat;
    for (int i = 0; i < n; i++) begin
      x = gen_operand(); y = gen_operand();
      ref_div(x, y, er, ef, sp);
      run_op(x, y, r, f, lat);
      checks++; if (r !== er) begin errors++; $display("FAIL rnd_result a=%h b=%h got=%h exp=%h", x, y, r, er); end
      checks++; if (f !== ef) begin errors++; $display("FAIL rnd_flags a=%h b=%h got=%b exp=%b", x, y, f, ef); end
      checks++;
      if (lat != (sp ? SPEC_LAT : NORM_LAT)) begin
        errors++; $display("FAIL rnd_latency a=%h b=%h got=%0d exp=%0d", x, y, lat, sp ? SPEC_LAT : NORM_LAT);
      end
    end
  endtask

  task automatic test_backpressure();
    int guard;
    int seen;
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 100) begin @(posedge clk); #1; guard++; end
    // A second request while the result is parked must be ignored.
    a = 32'h3F800000; b = 32'h40400000; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid cyc%0d got=%b exp=1", i, out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc%0d got=%b exp=0", i, in_ready); end
      checks++; if (result !== 32'h40400000) begin errors++; $display("FAIL bp_result cyc%0d got=%h exp=40400000", i, result); end
      checks++; if (flags !== 5'b0) begin errors++; $display("FAIL bp_flags cyc%0d got=%b exp=0", i, flags); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    seen = 0;
    repeat (35) begin @(posedge clk); #1; if (out_valid) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL bp_ignored_op got=%0d results exp=0", seen); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    logic [4:0] f;
    int lat, seen;
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL rstmid_result got=%h exp=0", result); end
    checks++; if (flags !== 5'h0) begin errors++; $display("FAIL rstmid_flags got=%b exp=0", flags); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_spurious got=%0d results exp=0", seen); end
    run_op(32'h40C00000, 32'h40000000, r, f, lat);
    checks++; if (r !== 32'h40400000) begin errors++; $display("FAIL rstmid_next_result got=%h exp=40400000", r); end
    checks++; if (f !== 5'b0) begin errors++; $display("FAIL rstmid_next_flags got=%b exp=0", f); end
    checks++; if (lat != NORM_LAT) begin errors++; $display("FAIL rstmid_next_latency got=%0d exp=%0d", lat, NORM_LAT); end
  endtask

  // Streaming with out_ready tied high and in_valid held; operands change
  // every cycle so anything sampled while busy would corrupt the results.
  task automatic test_back_to_back(input int n);
    logic [31:0] er;
    logic [4:0] ef;
    logic [36:0] e;
    bit sp;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0;
    exp_q.delete();
    out_ready = 1'b1;
    @(negedge clk);
    a = gen_operand(); b = gen_operand(); in_valid = 1'b1;
    while (got < n && cyc < n * 60) begin
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected got=%h", result);
        end else begin
          e = exp_q.pop_front();
          if (result !== e[31:0]) begin errors++; $display("FAIL b2b_result got=%h exp=%h", result, e[31:0]); end
          checks++;
          if (flags !== e[36:32]) begin errors++; $display("FAIL b2b_flags got=%b exp=%b", flags, e[36:32]); end
        end
        got++;
      end
      if (in_ready && in_valid) begin
        ref_div(a, b, er, ef, sp);
        exp_q.push_back({ef, er});
        sent++;
      end
      @(posedge clk); #1;
      a = gen_operand(); b = gen_operand();
      in_valid = (sent < n);
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++; if (got != n) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", got, n); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random(60);
    test_back_to_back(20);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
